// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: receiver state encoding and default
//               clock / line-rate constants used by both directions.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int unsigned c_DEFAULT_CLK_FREQ = 100_000_000;
    localparam int unsigned c_DEFAULT_BAUD     = 115_200;

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_START     = 3'd1;
    localparam logic [2:0] c_ST_DATA      = 3'd2;
    localparam logic [2:0] c_ST_STOP      = 3'd3;
    localparam logic [2:0] c_ST_WAIT_IDLE = 3'd4;

    typedef enum logic [2:0] {
        IDLE      = c_ST_IDLE,
        START     = c_ST_START,
        DATA      = c_ST_DATA,
        STOP      = c_ST_STOP,
        WAIT_IDLE = c_ST_WAIT_IDLE
    } rx_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchronizer for the asynchronous serial input.
//               Flops reset to the line idle level (1) so a reset never
//               looks like a start bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rxd,
    output logic rxd_s
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the pin into the clk domain
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= rxd;
            r_sync <= r_meta;
        end
    end

    assign rxd_s = r_sync;

endmodule : uart_rx_sync
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver. Mid-bit sampling from a start-edge
//               aligned counter, single-byte holding register with a
//               valid/ready handoff, framing-error and overrun pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = c_DEFAULT_CLK_FREQ,
    parameter int BAUD         = c_DEFAULT_BAUD,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    // Half-bit timing needs at least two cycles each side of the sample point
    if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
        $error("uart_rx: CLKS_PER_BIT must be at least 4");
    end

    localparam int               c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_HALF = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

    logic               w_rxd_s;
    rx_state_t          r_state,   w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt,     w_cnt_nxt;
    logic [2:0]         r_bit_idx, w_bit_idx_nxt;
    logic [7:0]         r_shreg,   w_shreg_nxt;
    logic               w_commit;
    logic               w_frame_err_set;
    logic [7:0]         r_rx_data;
    logic               r_rx_valid;
    logic               r_frame_err;
    logic               r_overrun;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .rxd   (rxd),
        .rxd_s (w_rxd_s)
    );

    // FSM state, bit timer, bit index and shift register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shreg   <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shreg   <= w_shreg_nxt;
        end
    end

    // Next-state, sampling and commit/error decisions
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_bit_idx_nxt   = r_bit_idx;
        w_shreg_nxt     = r_shreg;
        w_commit        = 1'b0;
        w_frame_err_set = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rxd_s) begin
                    w_state_nxt = START;
                    w_cnt_nxt   = c_HALF;
                end
            end
            START: begin
                if (r_cnt == '0) begin
                    if (w_rxd_s) begin
                        // Line went back high before mid-start: glitch
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt   = DATA;
                        w_cnt_nxt     = c_FULL;
                        w_bit_idx_nxt = 3'd0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_ONE;
                end
            end
            DATA: begin
                if (r_cnt == '0) begin
                    w_shreg_nxt   = {w_rxd_s, r_shreg[7:1]};
                    w_cnt_nxt     = c_FULL;
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = STOP;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_ONE;
                end
            end
            STOP: begin
                if (r_cnt == '0) begin
                    if (w_rxd_s) begin
                        w_commit    = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        // Wait for the line to recover so a break is one error
                        w_frame_err_set = 1'b1;
                        w_state_nxt     = WAIT_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_ONE;
                end
            end
            WAIT_IDLE: begin
                if (w_rxd_s) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Holding register, handoff and one-cycle status pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_frame_err_set;
            r_overrun   <= 1'b0;
            if (w_commit) begin
                // A drain on this same edge frees the slot for the new byte
                if (!r_rx_valid || rx_ready) begin
                    r_rx_data  <= r_shreg;
                    r_rx_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule : uart_rx
`default_nettype wire
